// File: rtl/fw_pkg.sv
// Shared definitions for the frame writer: state encoding and default frame geometry.
// The defaults match the 17x17 raster produced by the interpolator.
package fw_pkg;

  localparam int DEF_IMG_W = 17;
  localparam int DEF_IMG_H = 17;
  localparam int FRAME_PIX = DEF_IMG_W * DEF_IMG_H;

  typedef logic [1:0] state_t;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/frame_writer_if.sv
// Pixel-stream input, SRAM write port and status outputs of the frame writer.
// master = the side feeding pixels and watching status; slave = frame_writer.
interface frame_writer_if #(
  parameter int DW   = 8,
  parameter int AW   = 9,
  parameter int SW_W = 17
);
  logic            START;
  logic            I_VALID;
  logic [DW-1:0]   I_DATA;
  logic            WEN;
  logic [AW-1:0]   W_ADDR;
  logic [DW-1:0]   W_DATA;
  logic            ROW_END;
  logic            BUSY;
  logic            DONE;
  logic [SW_W-1:0] SUM;
  logic [DW-1:0]   MAX;
  logic            ERR;

  modport master (
    output START, I_VALID, I_DATA,
    input  WEN, W_ADDR, W_DATA, ROW_END, BUSY, DONE, SUM, MAX, ERR
  );

  modport slave (
    input  START, I_VALID, I_DATA,
    output WEN, W_ADDR, W_DATA, ROW_END, BUSY, DONE, SUM, MAX, ERR
  );
endinterface

// File: rtl/frame_stats.sv
// Per-frame pixel statistics: running sum (zero-extended, no saturation) and maximum.
// clr wins over en so a restart in the same cycle as a pixel discards that pixel.
module frame_stats #(
  parameter int DW   = 8,
  parameter int SW_W = 17
) (
  input  logic            clk,
  input  logic            RST,
  input  logic            clr,
  input  logic            en,
  input  logic [DW-1:0]   din,
  output logic [SW_W-1:0] sum,
  output logic [DW-1:0]   peak
);

  logic [SW_W-1:0] sum_reg;
  logic [DW-1:0]   peak_reg;

  always_ff @(posedge clk) begin
    if (RST || clr) begin
      sum_reg  <= '0;
      peak_reg <= '0;
    end else if (en) begin
      sum_reg <= sum_reg + {{(SW_W-DW){1'b0}}, din};
      if (din > peak_reg) begin
        peak_reg <= din;
      end
    end
  end

  assign sum  = sum_reg;
  assign peak = peak_reg;

endmodule

// File: rtl/frame_writer.sv
// Writes the raster pixel stream into the result SRAM at its raster address,
// tracks per-frame SUM/MAX, and reports frame completion and stray pixels.
module frame_writer
  import fw_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int DW    = 8,
  parameter int AW    = 9,
  parameter int SW_W  = 17
) (
  input  logic           clk,
  input  logic           RST,
  frame_writer_if.slave  bus
);

  localparam int FRAME_N = IMG_W * IMG_H;
  localparam int CW      = cnt_width(IMG_W);
  localparam int RW      = cnt_width(IMG_H);

  localparam logic [AW-1:0] ADDR_LAST = AW'(FRAME_N - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);

  logic [1:0]      state_reg;
  logic [1:0]      state_next;
  logic [AW-1:0]   addr_reg;
  logic [CW-1:0]   col_reg;
  logic [RW-1:0]   row_reg;

  logic            wen_reg;
  logic [AW-1:0]   w_addr_reg;
  logic [DW-1:0]   w_data_reg;
  logic            row_end_reg;
  logic            busy_reg;
  logic            done_reg;
  logic            err_reg;

  logic            accept;
  logic            stray;
  logic            col_last;
  logic            last_pix;
  logic [SW_W-1:0] stat_sum;
  logic [DW-1:0]   stat_peak;

  // START dominates: any pixel presented alongside it is dropped silently.
  assign accept   = (state_reg == S_RUN) && bus.I_VALID && !bus.START;
  assign stray    = (state_reg != S_RUN) && bus.I_VALID && !bus.START;
  assign col_last = (col_reg == COL_LAST);
  assign last_pix = (addr_reg == ADDR_LAST);

  always_comb begin
    state_next = state_reg;
    if (bus.START) begin
      state_next = S_RUN;
    end else begin
      case (state_reg)
        S_IDLE:  state_next = S_IDLE;
        S_RUN:   if (accept && last_pix) state_next = S_FLUSH;
        S_FLUSH: state_next = S_DONE;
        S_DONE:  state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_reg   <= S_IDLE;
      addr_reg    <= '0;
      col_reg     <= '0;
      row_reg     <= '0;
      wen_reg     <= 1'b1;
      w_addr_reg  <= '0;
      w_data_reg  <= '0;
      row_end_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      wen_reg     <= !accept;
      row_end_reg <= accept && col_last;
      busy_reg    <= (state_next == S_RUN) || (state_next == S_FLUSH);
      done_reg    <= (state_next == S_DONE);

      // Address/data hold their last value between writes.
      if (accept) begin
        w_addr_reg <= addr_reg;
        w_data_reg <= bus.I_DATA;
      end

      if (bus.START) begin
        addr_reg <= '0;
        col_reg  <= '0;
        row_reg  <= '0;
      end else if (accept) begin
        addr_reg <= addr_reg + 1'b1;
        if (col_last) begin
          col_reg <= '0;
          row_reg <= (row_reg == ROW_LAST) ? '0 : row_reg + 1'b1;
        end else begin
          col_reg <= col_reg + 1'b1;
        end
      end

      if (bus.START) begin
        err_reg <= 1'b0;
      end else if (stray) begin
        err_reg <= 1'b1;
      end
    end
  end

  frame_stats #(
    .DW   (DW),
    .SW_W (SW_W)
  ) u_stats (
    .clk  (clk),
    .RST  (RST),
    .clr  (bus.START),
    .en   (accept),
    .din  (bus.I_DATA),
    .sum  (stat_sum),
    .peak (stat_peak)
  );

  assign bus.WEN     = wen_reg;
  assign bus.W_ADDR  = w_addr_reg;
  assign bus.W_DATA  = w_data_reg;
  assign bus.ROW_END = row_end_reg;
  assign bus.BUSY    = busy_reg;
  assign bus.DONE    = done_reg;
  assign bus.SUM     = stat_sum;
  assign bus.MAX     = stat_peak;
  assign bus.ERR     = err_reg;

endmodule

// File: tb/tb_frame_writer.sv
// Directed bench for frame_writer: full, gapped, stray, excess, abort and reset-mid-frame scenarios.
module tb_frame_writer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  frame_writer_if #(.DW(8), .AW(9), .SW_W(17)) bus();

  frame_writer dut (
    .clk (clk),
    .RST (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Observation of the write port, sampled on the falling edge.
  int         cyc = 0;
  logic [8:0] wa_q[$];
  logic [7:0] wd_q[$];
  logic [8:0] re_q[$];
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         last_wr_cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (bus.WEN === 1'b0) begin
      wa_q.push_back(bus.W_ADDR);
      wd_q.push_back(bus.W_DATA);
      last_wr_cyc = cyc;
      if (bus.ROW_END === 1'b1) re_q.push_back(bus.W_ADDR);
    end else if (bus.ROW_END === 1'b1) begin
      re_q.push_back(9'h1FF);
    end
    if (bus.DONE === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic drive(input logic s, input logic v, input logic [7:0] d);
    @(negedge clk);
    bus.START   = s;
    bus.I_VALID = v;
    bus.I_DATA  = d;
  endtask

  task automatic mon_clear();
    @(posedge clk);
    #2;
    wa_q.delete();
    wd_q.delete();
    re_q.delete();
    done_cnt = 0;
    done_cyc = 0;
    last_wr_cyc = 0;
  endtask

  // Idle the inputs and wait (bounded) for DONE, then a few more cycles to catch a repeat.
  task automatic wait_done();
    drive(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 20 && done_cnt == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [46:0] obs;
    bus.START = 1'b0; bus.I_VALID = 1'b0; bus.I_DATA = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    obs = {bus.WEN, bus.W_ADDR, bus.W_DATA, bus.ROW_END, bus.BUSY, bus.DONE, bus.SUM, bus.MAX, bus.ERR};
    total++;
    if (obs !== {1'b1, 9'd0, 8'd0, 1'b0, 1'b0, 1'b0, 17'd0, 8'd0, 1'b0}) begin
      bad++; $display("FAIL reset_outputs got=%h want=%h", obs, {1'b1, 46'd0});
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.BUSY !== 1'b0 || bus.WEN !== 1'b1) begin
      bad++; $display("FAIL reset_idle busy=%b wen=%b want busy=0 wen=1", bus.BUSY, bus.WEN);
    end
    $display("test_reset done");
  endtask

  task automatic test_full_frame();
    int errs = 0;
    mon_clear();
    drive(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 289; k++) drive(1'b0, 1'b1, 8'(k));
    wait_done();
    total++;
    if (wa_q.size() != 289) begin bad++; $display("FAIL full_wcount got=%0d want=289", wa_q.size()); end
    for (int k = 0; k < wa_q.size(); k++) if (wa_q[k] !== 9'(k) || wd_q[k] !== 8'(k)) errs++;
    total++;
    if (errs != 0) begin bad++; $display("FAIL full_wseq bad_writes=%0d want=0", errs); end
    errs = 0;
    for (int i = 0; i < re_q.size(); i++) if (re_q[i] !== 9'(16 + 17*i)) errs++;
    total++;
    if (re_q.size() != 17 || errs != 0) begin
      bad++; $display("FAIL full_row_end count=%0d bad=%0d want count=17 bad=0", re_q.size(), errs);
    end
    total++;
    if (done_cnt != 1 || done_cyc != last_wr_cyc + 1) begin
      bad++; $display("FAIL full_done count=%0d at=%0d want count=1 at=%0d", done_cnt, done_cyc, last_wr_cyc + 1);
    end
    total++;
    if (bus.SUM !== 17'd33168) begin bad++; $display("FAIL full_sum got=%0d want=33168", bus.SUM); end
    total++;
    if (bus.MAX !== 8'd255 || bus.ERR !== 1'b0 || bus.BUSY !== 1'b0) begin
      bad++; $display("FAIL full_status max=%0d err=%b busy=%b want 255 0 0", bus.MAX, bus.ERR, bus.BUSY);
    end
    $display("test_full_frame writes=%0d sum=%0d", wa_q.size(), bus.SUM);
  endtask

  task automatic test_gapped();
    int errs = 0;
    int gap_bad = 0;
    int exp_sum = 0;
    mon_clear();
    drive(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 289; k++) begin
      drive(1'b0, 1'b1, 8'(k));
      exp_sum += k % 256;
      if (k % 5 == 4) begin
        drive(1'b0, 1'b0, 8'hEE);
        drive(1'b0, 1'b0, 8'hEE);
        if (bus.WEN !== 1'b1) gap_bad++;
        drive(1'b0, 1'b0, 8'hEE);
        if (bus.WEN !== 1'b1) gap_bad++;
      end
    end
    wait_done();
    for (int k = 0; k < wa_q.size(); k++) if (wa_q[k] !== 9'(k) || wd_q[k] !== 8'(k)) errs++;
    total++;
    if (wa_q.size() != 289 || errs != 0) begin
      bad++; $display("FAIL gap_wseq count=%0d bad=%0d want count=289 bad=0", wa_q.size(), errs);
    end
    total++;
    if (gap_bad != 0) begin bad++; $display("FAIL gap_wen low_in_gap=%0d want=0", gap_bad); end
    total++;
    if (re_q.size() != 17) begin bad++; $display("FAIL gap_row_end count=%0d want=17", re_q.size()); end
    total++;
    if (bus.SUM !== 17'(exp_sum) || bus.MAX !== 8'd255) begin
      bad++; $display("FAIL gap_stats sum=%0d max=%0d want sum=%0d max=255", bus.SUM, bus.MAX, exp_sum);
    end
    total++;
    if (done_cnt != 1) begin bad++; $display("FAIL gap_done count=%0d want=1", done_cnt); end
    $display("test_gapped writes=%0d sum=%0d", wa_q.size(), bus.SUM);
  endtask

  task automatic test_stray();
    drive(1'b0, 1'b1, 8'hAA);
    drive(1'b0, 1'b0, 8'h00);
    total++;
    if (bus.ERR !== 1'b1 || bus.WEN !== 1'b1) begin
      bad++; $display("FAIL stray_err err=%b wen=%b want err=1 wen=1", bus.ERR, bus.WEN);
    end
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    total++;
    if (bus.ERR !== 1'b0 || bus.BUSY !== 1'b1) begin
      bad++; $display("FAIL stray_clear err=%b busy=%b want err=0 busy=1", bus.ERR, bus.BUSY);
    end
    $display("test_stray err_set_then_cleared");
  endtask

  task automatic test_excess();
    mon_clear();
    drive(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 290; k++) drive(1'b0, 1'b1, 8'(k));
    wait_done();
    total++;
    if (wa_q.size() != 289) begin bad++; $display("FAIL excess_wcount got=%0d want=289", wa_q.size()); end
    total++;
    if (bus.ERR !== 1'b1) begin bad++; $display("FAIL excess_err got=%b want=1", bus.ERR); end
    total++;
    if (done_cnt != 1) begin bad++; $display("FAIL excess_done count=%0d want=1", done_cnt); end
    total++;
    if (bus.SUM !== 17'd33168) begin bad++; $display("FAIL excess_sum got=%0d want=33168", bus.SUM); end
    $display("test_excess writes=%0d err=%b", wa_q.size(), bus.ERR);
  endtask

  task automatic test_abort();
    int errs = 0;
    mon_clear();
    drive(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 100; k++) drive(1'b0, 1'b1, 8'(k + 9));
    drive(1'b1, 1'b1, 8'h77);
    for (int k = 0; k < 289; k++) drive(1'b0, 1'b1, 8'h01);
    wait_done();
    total++;
    if (wa_q.size() != 389) begin bad++; $display("FAIL abort_wcount got=%0d want=389", wa_q.size()); end
    for (int k = 0; k < wa_q.size(); k++) begin
      if (k < 100) begin
        if (wa_q[k] !== 9'(k) || wd_q[k] !== 8'(k + 9)) errs++;
      end else begin
        if (wa_q[k] !== 9'(k - 100) || wd_q[k] !== 8'h01) errs++;
      end
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL abort_wseq bad_writes=%0d want=0", errs); end
    total++;
    if (bus.SUM !== 17'd289 || bus.MAX !== 8'd1) begin
      bad++; $display("FAIL abort_stats sum=%0d max=%0d want sum=289 max=1", bus.SUM, bus.MAX);
    end
    total++;
    if (done_cnt != 1 || bus.ERR !== 1'b0) begin
      bad++; $display("FAIL abort_done count=%0d err=%b want count=1 err=0", done_cnt, bus.ERR);
    end
    $display("test_abort writes=%0d sum=%0d", wa_q.size(), bus.SUM);
  endtask

  task automatic test_reset_mid();
    logic [46:0] obs;
    int errs = 0;
    int exp_sum = 0;
    int exp_max = 0;
    drive(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 50; k++) drive(1'b0, 1'b1, 8'(k + 3));
    @(negedge clk);
    rst = 1'b1; bus.START = 1'b0; bus.I_VALID = 1'b1; bus.I_DATA = 8'h5A;
    @(negedge clk);
    obs = {bus.WEN, bus.W_ADDR, bus.W_DATA, bus.ROW_END, bus.BUSY, bus.DONE, bus.SUM, bus.MAX, bus.ERR};
    total++;
    if (obs !== {1'b1, 46'd0}) begin bad++; $display("FAIL rstmid_outputs got=%h want=%h", obs, {1'b1, 46'd0}); end
    rst = 1'b0; bus.I_VALID = 1'b0;
    mon_clear();
    drive(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 289; k++) begin
      drive(1'b0, 1'b1, 8'(k * 7));
      exp_sum += (k * 7) % 256;
      if ((k * 7) % 256 > exp_max) exp_max = (k * 7) % 256;
    end
    wait_done();
    for (int k = 0; k < wa_q.size(); k++) if (wa_q[k] !== 9'(k) || wd_q[k] !== 8'(k * 7)) errs++;
    total++;
    if (wa_q.size() != 289 || errs != 0) begin
      bad++; $display("FAIL rstmid_wseq count=%0d bad=%0d want count=289 bad=0", wa_q.size(), errs);
    end
    total++;
    if (bus.SUM !== 17'(exp_sum) || bus.MAX !== 8'(exp_max)) begin
      bad++; $display("FAIL rstmid_stats sum=%0d max=%0d want sum=%0d max=%0d", bus.SUM, bus.MAX, exp_sum, exp_max);
    end
    total++;
    if (done_cnt != 1 || bus.ERR !== 1'b0) begin
      bad++; $display("FAIL rstmid_done count=%0d err=%b want count=1 err=0", done_cnt, bus.ERR);
    end
    $display("test_reset_mid writes=%0d sum=%0d", wa_q.size(), bus.SUM);
  endtask

  initial begin
    bus.START = 1'b0;
    bus.I_VALID = 1'b0;
    bus.I_DATA = 8'h00;
    test_reset();
    test_full_frame();
    test_gapped();
    test_stray();
    test_excess();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
